mem_access_unit: RTL and testbench

- Data-memory stage of the 5-stage ARM pipeline, between the EX/MEM register and mem_wb_reg.
- Turns load/store control plus the ALU address into a req/ack transaction on the data-memory port.
- Stalls upstream while a transaction is outstanding, and hands registered control, result and load data to mem_wb_reg.
- A watchdog aborts transactions that never complete.

---
 rtl/mem_access_unit_pkg.sv | 25 ++
 rtl/mem_load_align.sv | 34 +++
 rtl/mem_access_unit.sv | 184 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory stage: state encoding, access size,
// byte-enable constants and the byte-lane decode helper.
package mem_access_unit_pkg;

  localparam int REG_ADDR_WIDTH_DEFAULT = 4;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mau_state_t;

  typedef enum logic {
    SIZE_WORD = 1'b0,
    SIZE_BYTE = 1'b1
  } access_size_t;

  // One-hot byte enable for the lane selected by the low address bits.
  function automatic logic [3:0] byte_lane_be(input logic [1:0] offset);
    return 4'b0001 << offset;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-path formatter: byte loads pick one lane and zero-extend it, word loads
// rotate the returned word so an unaligned address behaves like ARMv4.
module mem_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0]  rdata,
  input  logic [1:0]   offset,
  input  access_size_t size,
  output logic [31:0]  load_data
);

  // Select a lane or rotate the word depending on the access size.
  always_comb begin
    load_data = 32'h0;
    if (size == SIZE_BYTE) begin
      case (offset)
        2'd0: load_data = {24'h0, rdata[7:0]};
        2'd1: load_data = {24'h0, rdata[15:8]};
        2'd2: load_data = {24'h0, rdata[23:16]};
        2'd3: load_data = {24'h0, rdata[31:24]};
        default: load_data = 32'h0;
      endcase
    end else begin
      case (offset)
        2'd0: load_data = rdata;
        2'd1: load_data = {rdata[7:0], rdata[31:8]};
        2'd2: load_data = {rdata[15:0], rdata[31:16]};
        2'd3: load_data = {rdata[23:0], rdata[31:24]};
        default: load_data = rdata;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory stage: turns load/store control into a req/ack transaction,
// stalls upstream while it is outstanding, aborts it through a watchdog, and
// registers control, result and formatted load data for mem_wb_reg.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT,
  parameter int TIMEOUT_CYCLES = 15,
  parameter int TIMEOUT_WIDTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  input  logic                      reg_write_enable_in,
  input  logic                      mem_write_enable_in,
  input  logic                      mem_to_reg_select_in,
  input  logic                      byte_access_in,
  input  logic [31:0]               alu_result_in,
  input  logic [31:0]               store_data_in,
  input  logic [REG_ADDR_WIDTH-1:0] rd_in,
  output logic                      stall_out,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [31:0]               dmem_addr,
  output logic [31:0]               dmem_wdata,
  output logic [3:0]                dmem_be,
  input  logic                      dmem_ack,
  input  logic [31:0]               dmem_rdata,
  output logic                      valid_out,
  output logic                      reg_write_enable_out,
  output logic                      mem_to_reg_select_out,
  output logic [REG_ADDR_WIDTH-1:0] rd_out,
  output logic [31:0]               alu_result_out,
  output logic [31:0]               load_data_out,
  output logic                      mem_fault_out
);

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

  mau_state_t                 state;
  logic [TIMEOUT_WIDTH-1:0]   wd_cnt;

  logic                       hold_reg_write;
  logic                       hold_is_load;
  logic [REG_ADDR_WIDTH-1:0]  hold_rd;
  logic [31:0]                hold_alu_result;
  logic [1:0]                 hold_offset;
  access_size_t               hold_size;

  logic                       mem_op;
  logic                       is_store;
  logic                       ack_seen;
  logic                       timeout_hit;
  access_size_t               cap_size;
  logic [3:0]                 cap_be;
  logic [31:0]                cap_wdata;
  logic [31:0]                aligned_data;

  assign mem_op      = valid_in & (mem_write_enable_in | mem_to_reg_select_in);
  assign is_store    = mem_write_enable_in;
  assign ack_seen    = dmem_req & dmem_ack;
  assign timeout_hit = (wd_cnt == TIMEOUT_LIMIT);
  assign cap_size    = byte_access_in ? SIZE_BYTE : SIZE_WORD;

  // Upstream holds while a request is about to start or is still waiting;
  // the ack cycle and the abort cycle let the pipeline advance.
  always_comb begin
    stall_out = 1'b0;
    if (!reset) begin
      if (state == IDLE) begin
        stall_out = mem_op;
      end else begin
        stall_out = ~ack_seen & ~timeout_hit;
      end
    end
  end

  // Store lane placement and byte enables for the request being captured.
  always_comb begin
    cap_be    = BE_WORD;
    cap_wdata = 32'h0;
    if (cap_size == SIZE_BYTE) begin
      cap_be = byte_lane_be(alu_result_in[1:0]);
    end
    if (is_store) begin
      cap_wdata = (cap_size == SIZE_BYTE) ? {4{store_data_in[7:0]}} : store_data_in;
    end
  end

  mem_load_align u_load_align (
    .rdata     (dmem_rdata),
    .offset    (hold_offset),
    .size      (hold_size),
    .load_data (aligned_data)
  );

  // Transaction state machine, watchdog and registered stage outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= IDLE;
      wd_cnt                <= '0;
      dmem_req              <= 1'b0;
      dmem_we               <= 1'b0;
      dmem_addr             <= 32'h0;
      dmem_wdata            <= 32'h0;
      dmem_be               <= BE_NONE;
      hold_reg_write        <= 1'b0;
      hold_is_load          <= 1'b0;
      hold_rd               <= '0;
      hold_alu_result       <= 32'h0;
      hold_offset           <= 2'b00;
      hold_size             <= SIZE_WORD;
      valid_out             <= 1'b0;
      reg_write_enable_out  <= 1'b0;
      mem_to_reg_select_out <= 1'b0;
      rd_out                <= '0;
      alu_result_out        <= 32'h0;
      load_data_out         <= 32'h0;
      mem_fault_out         <= 1'b0;
    end else begin
      mem_fault_out <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op) begin
            state                 <= WAIT;
            wd_cnt                <= TIMEOUT_WIDTH'(1);
            dmem_req              <= 1'b1;
            dmem_we               <= is_store;
            dmem_addr             <= {alu_result_in[31:2], 2'b00};
            dmem_wdata            <= cap_wdata;
            dmem_be               <= cap_be;
            hold_reg_write        <= reg_write_enable_in;
            hold_is_load          <= mem_to_reg_select_in & ~is_store;
            hold_rd               <= rd_in;
            hold_alu_result       <= alu_result_in;
            hold_offset           <= alu_result_in[1:0];
            hold_size             <= cap_size;
            valid_out             <= 1'b0;
            reg_write_enable_out  <= 1'b0;
            mem_to_reg_select_out <= 1'b0;
            rd_out                <= '0;
            alu_result_out        <= 32'h0;
            load_data_out         <= 32'h0;
          end else begin
            valid_out             <= valid_in;
            reg_write_enable_out  <= valid_in & reg_write_enable_in;
            mem_to_reg_select_out <= valid_in & mem_to_reg_select_in;
            rd_out                <= valid_in ? rd_in : '0;
            alu_result_out        <= valid_in ? alu_result_in : 32'h0;
            load_data_out         <= 32'h0;
          end
        end
        WAIT: begin
          if (ack_seen) begin
            state                 <= IDLE;
            wd_cnt                <= '0;
            dmem_req              <= 1'b0;
            valid_out             <= 1'b1;
            reg_write_enable_out  <= hold_reg_write;
            mem_to_reg_select_out <= hold_is_load;
            rd_out                <= hold_rd;
            alu_result_out        <= hold_alu_result;
            load_data_out         <= hold_is_load ? aligned_data : 32'h0;
          end else if (timeout_hit) begin
            state                 <= IDLE;
            wd_cnt                <= '0;
            dmem_req              <= 1'b0;
            mem_fault_out         <= 1'b1;
            valid_out             <= 1'b0;
            reg_write_enable_out  <= 1'b0;
            mem_to_reg_select_out <= 1'b0;
            rd_out                <= '0;
            alu_result_out        <= 32'h0;
            load_data_out         <= 32'h0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a vector table of single transactions
// plus hand-written watchdog, ack-at-timeout and mid-WAIT reset sequences.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic        reg_write_enable_in;
  logic        mem_write_enable_in;
  logic        mem_to_reg_select_in;
  logic        byte_access_in;
  logic [31:0] alu_result_in;
  logic [31:0] store_data_in;
  logic [3:0]  rd_in;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        valid_out;
  logic        reg_write_enable_out;
  logic        mem_to_reg_select_out;
  logic [3:0]  rd_out;
  logic [31:0] alu_result_out;
  logic [31:0] load_data_out;
  logic        mem_fault_out;

  int total = 0;
  int bad   = 0;

  mem_access_unit #(
    .REG_ADDR_WIDTH (4),
    .TIMEOUT_CYCLES (15),
    .TIMEOUT_WIDTH  (4)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .valid_in              (valid_in),
    .reg_write_enable_in   (reg_write_enable_in),
    .mem_write_enable_in   (mem_write_enable_in),
    .mem_to_reg_select_in  (mem_to_reg_select_in),
    .byte_access_in        (byte_access_in),
    .alu_result_in         (alu_result_in),
    .store_data_in         (store_data_in),
    .rd_in                 (rd_in),
    .stall_out             (stall_out),
    .dmem_req              (dmem_req),
    .dmem_we               (dmem_we),
    .dmem_addr             (dmem_addr),
    .dmem_wdata            (dmem_wdata),
    .dmem_be               (dmem_be),
    .dmem_ack              (dmem_ack),
    .dmem_rdata            (dmem_rdata),
    .valid_out             (valid_out),
    .reg_write_enable_out  (reg_write_enable_out),
    .mem_to_reg_select_out (mem_to_reg_select_out),
    .rd_out                (rd_out),
    .alu_result_out        (alu_result_out),
    .load_data_out         (load_data_out),
    .mem_fault_out         (mem_fault_out)
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        valid, rw, we, m2r, byt;
    logic [31:0] alu, sdata;
    logic [3:0]  rd;
    int          ack_delay;
    logic [31:0] rdata;
    logic        is_mem;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    logic        e_we;
    logic        e_valid, e_rw, e_m2r;
    logic [31:0] e_alu, e_load;
    logic [3:0]  e_rd;
  } vec_t;

  vec_t vecs[11];

  // Compare one value and record the outcome.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one table vector starting just after a clock edge and check it.
  task automatic applyStimulus(input vec_t v, input string tag);
    valid_in             = v.valid;
    reg_write_enable_in  = v.rw;
    mem_write_enable_in  = v.we;
    mem_to_reg_select_in = v.m2r;
    byte_access_in       = v.byt;
    alu_result_in        = v.alu;
    store_data_in        = v.sdata;
    rd_in                = v.rd;
    dmem_ack             = 1'b0;
    dmem_rdata           = 32'h0;
    #1;
    checkOutput({tag, " stall_idle"}, stall_out, v.is_mem);
    @(posedge clk); #1;
    if (v.is_mem) begin
      checkOutput({tag, " req"}, dmem_req, 1'b1);
      checkOutput({tag, " addr"}, dmem_addr, v.e_addr);
      checkOutput({tag, " we"}, dmem_we, v.e_we);
      checkOutput({tag, " bubble"}, valid_out, 1'b0);
      if (v.e_we) begin
        checkOutput({tag, " be"}, dmem_be, v.e_be);
        checkOutput({tag, " wdata"}, dmem_wdata, v.e_wdata);
      end
      for (int k = 0; k < v.ack_delay; k++) begin
        checkOutput({tag, " stall_wait"}, stall_out, 1'b1);
        @(posedge clk); #1;
        checkOutput({tag, " req_held"}, dmem_req, 1'b1);
        checkOutput({tag, " we_held"}, dmem_we, v.e_we);
        if (v.e_we) checkOutput({tag, " wdata_held"}, dmem_wdata, v.e_wdata);
      end
      rd_in         = ~v.rd;
      alu_result_in = ~v.alu;
      dmem_ack      = 1'b1;
      dmem_rdata    = v.rdata;
      #1;
      checkOutput({tag, " stall_ack"}, stall_out, 1'b0);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
    end
    valid_in = 1'b0;
    checkOutput({tag, " valid_out"}, valid_out, v.e_valid);
    checkOutput({tag, " rw_out"}, reg_write_enable_out, v.e_rw);
    checkOutput({tag, " m2r_out"}, mem_to_reg_select_out, v.e_m2r);
    checkOutput({tag, " req_done"}, dmem_req, 1'b0);
    checkOutput({tag, " fault"}, mem_fault_out, 1'b0);
    if (v.e_valid) begin
      checkOutput({tag, " rd_out"}, rd_out, v.e_rd);
      checkOutput({tag, " alu_out"}, alu_result_out, v.e_alu);
      checkOutput({tag, " load_out"}, load_data_out, v.e_load);
    end
  endtask

  initial begin
    vecs[0]  = '{1,1,0,0,0, 32'h42, 32'h0, 4'd3, 0, 32'h0, 0,
                 32'h0, 32'h0, 4'h0, 0, 1,1,0, 32'h42, 32'h0, 4'd3};
    vecs[1]  = '{0,1,1,0,0, 32'h55, 32'h1, 4'd6, 0, 32'h0, 0,
                 32'h0, 32'h0, 4'h0, 0, 0,0,0, 32'h0, 32'h0, 4'd0};
    vecs[2]  = '{1,1,0,1,0, 32'h1002, 32'h0, 4'd5, 0, 32'hAABBCCDD, 1,
                 32'h1000, 32'h0, 4'hF, 0, 1,1,1, 32'h1002, 32'hCCDDAABB, 4'd5};
    vecs[3]  = '{1,0,1,0,1, 32'h2003, 32'h123456A5, 4'd7, 2, 32'h5A5A5A5A, 1,
                 32'h2000, 32'hA5A5A5A5, 4'b1000, 1, 1,0,0, 32'h2003, 32'h0, 4'd7};
    vecs[4]  = '{1,1,0,1,1, 32'h1, 32'h0, 4'd2, 1, 32'h11223344, 1,
                 32'h0, 32'h0, 4'b0010, 0, 1,1,1, 32'h1, 32'h33, 4'd2};
    vecs[5]  = '{1,1,0,1,0, 32'h3003, 32'h0, 4'd8, 0, 32'h11223344, 1,
                 32'h3000, 32'h0, 4'hF, 0, 1,1,1, 32'h3003, 32'h22334411, 4'd8};
    vecs[6]  = '{1,0,1,0,0, 32'h4001, 32'hDEADBEEF, 4'd1, 0, 32'h5A5A5A5A, 1,
                 32'h4000, 32'hDEADBEEF, 4'hF, 1, 1,0,0, 32'h4001, 32'h0, 4'd1};
    vecs[7]  = '{1,1,0,1,1, 32'h102, 32'h0, 4'd10, 3, 32'h11223344, 1,
                 32'h100, 32'h0, 4'b0100, 0, 1,1,1, 32'h102, 32'h22, 4'd10};
    vecs[8]  = '{1,1,1,1,0, 32'h10, 32'h99, 4'd11, 0, 32'h5A5A5A5A, 1,
                 32'h10, 32'h99, 4'hF, 1, 1,1,0, 32'h10, 32'h0, 4'd11};
    vecs[9]  = '{1,0,1,0,1, 32'h0, 32'h000000FF, 4'd0, 0, 32'h0, 1,
                 32'h0, 32'hFFFFFFFF, 4'b0001, 1, 1,0,0, 32'h0, 32'h0, 4'd0};
    vecs[10] = '{1,0,0,0,0, 32'hFFFFFFFF, 32'h0, 4'd12, 0, 32'h0, 0,
                 32'h0, 32'h0, 4'h0, 0, 1,0,0, 32'hFFFFFFFF, 32'h0, 4'd12};

    reset                = 1'b1;
    valid_in             = 1'b0;
    reg_write_enable_in  = 1'b0;
    mem_write_enable_in  = 1'b0;
    mem_to_reg_select_in = 1'b0;
    byte_access_in       = 1'b0;
    alu_result_in        = 32'h0;
    store_data_in        = 32'h0;
    rd_in                = 4'd0;
    dmem_ack             = 1'b0;
    dmem_rdata           = 32'h0;
    #1;
    checkOutput("rst req", dmem_req, 1'b0);
    checkOutput("rst valid", valid_out, 1'b0);
    checkOutput("rst stall", stall_out, 1'b0);
    checkOutput("rst fault", mem_fault_out, 1'b0);
    checkOutput("rst addr", dmem_addr, 32'h0);
    checkOutput("rst load", load_data_out, 32'h0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Watchdog: a load that is never acknowledged.
    valid_in = 1'b1; reg_write_enable_in = 1'b1; mem_to_reg_select_in = 1'b1;
    mem_write_enable_in = 1'b0; byte_access_in = 1'b0;
    alu_result_in = 32'h20; rd_in = 4'd4;
    #1;
    checkOutput("to stall_idle", stall_out, 1'b1);
    @(posedge clk); #1;
    for (int i = 1; i <= 15; i++) begin
      checkOutput($sformatf("to stall_c%0d", i), stall_out, (i == 15) ? 1'b0 : 1'b1);
      checkOutput($sformatf("to req_c%0d", i), dmem_req, 1'b1);
      checkOutput($sformatf("to fault_c%0d", i), mem_fault_out, 1'b0);
      @(posedge clk); #1;
    end
    checkOutput("to fault", mem_fault_out, 1'b1);
    checkOutput("to req", dmem_req, 1'b0);
    checkOutput("to valid", valid_out, 1'b0);
    checkOutput("to rw", reg_write_enable_out, 1'b0);
    valid_in = 1'b1; reg_write_enable_in = 1'b1; mem_to_reg_select_in = 1'b0;
    alu_result_in = 32'h77; rd_in = 4'd9;
    #1;
    checkOutput("to next stall", stall_out, 1'b0);
    @(posedge clk); #1;
    valid_in = 1'b0;
    checkOutput("to next valid", valid_out, 1'b1);
    checkOutput("to next rd", rd_out, 4'd9);
    checkOutput("to next alu", alu_result_out, 32'h77);
    checkOutput("to fault pulse", mem_fault_out, 1'b0);

    // Ack arriving in the timeout cycle completes normally.
    valid_in = 1'b1; reg_write_enable_in = 1'b1; mem_to_reg_select_in = 1'b1;
    mem_write_enable_in = 1'b0; byte_access_in = 1'b1;
    alu_result_in = 32'h23; rd_in = 4'd6;
    @(posedge clk); #1;
    for (int i = 1; i < 15; i++) begin
      @(posedge clk); #1;
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h11223344;
    #1;
    checkOutput("race stall", stall_out, 1'b0);
    @(posedge clk); #1;
    dmem_ack = 1'b0; valid_in = 1'b0;
    checkOutput("race fault", mem_fault_out, 1'b0);
    checkOutput("race valid", valid_out, 1'b1);
    checkOutput("race rw", reg_write_enable_out, 1'b1);
    checkOutput("race load", load_data_out, 32'h11);

    // Reset asserted between edges while waiting.
    valid_in = 1'b1; reg_write_enable_in = 1'b1; mem_to_reg_select_in = 1'b1;
    mem_write_enable_in = 1'b0; byte_access_in = 1'b0;
    alu_result_in = 32'h40; rd_in = 4'd13;
    @(posedge clk); #1;
    checkOutput("rstw req_before", dmem_req, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("rstw req", dmem_req, 1'b0);
    checkOutput("rstw stall", stall_out, 1'b0);
    checkOutput("rstw valid", valid_out, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0; valid_in = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    checkOutput("stale stall", stall_out, 1'b0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    checkOutput("stale valid", valid_out, 1'b0);
    checkOutput("stale req", dmem_req, 1'b0);
    checkOutput("stale fault", mem_fault_out, 1'b0);
    applyStimulus(vecs[2], "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
